// File: rtl/ising_solution_reader.sv
// Readout stage for top_ising: waits for a stable phase vector, normalises it
// to the local-field spin and scores its cut over the negative couplings.
module ising_solution_reader #(
  parameter  int N              = 6,
  parameter  int REF_INDEX      = N - 1,
  parameter  int STABLE_CYCLES  = 16,
  parameter  int TIMEOUT_CYCLES = 4096,
  localparam int P              = N * (N - 1) / 2,
  localparam int CW             = $clog2(P + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N*(N-1)-1:0] weights,
  input  logic [N-1:0]       phase,
  input  logic               start,
  output logic               busy,
  output logic               sol_valid,
  input  logic               sol_ready,
  output logic [N-1:0]       solution,
  output logic [CW-1:0]      cut_size,
  output logic               timed_out
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int IW = $clog2(N + 1);
  localparam int PW = $clog2(P + 1);

  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [SW-1:0] STAB_MAX  = SW'(STABLE_CYCLES);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [PW-1:0] PAIR_END  = PW'(P);
  localparam logic [IW-1:0] N_LAST    = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    SCORE,
    DONE
  } state_t;

  state_t              state_q, state_d;
  logic [N-1:0]        ps1_q, ps2_q, psp_q;
  logic [SW-1:0]       stab_q, stab_d;
  logic [TW-1:0]       to_q, to_d;
  logic [CW-1:0]       cut_q, cut_d;
  logic [PW-1:0]       pidx_q, pidx_d;
  logic [IW-1:0]       i_q, i_d;
  logic [IW-1:0]       j_q, j_d;
  logic [N-1:0]        cap_q, cap_d;
  logic [N*(N-1)-1:0]  wcap_q, wcap_d;
  logic                tout_q, tout_d;
  logic                same;
  logic [N-1:0]        norm;

  assign same = (ps2_q == psp_q);
  assign norm = ps2_q ^ {N{~ps2_q[REF_INDEX]}};

  always_comb begin
    state_d   = state_q;
    stab_d    = stab_q;
    to_d      = to_q;
    cut_d     = cut_q;
    pidx_d    = pidx_q;
    i_d       = i_q;
    j_d       = j_q;
    cap_d     = cap_q;
    wcap_d    = wcap_q;
    tout_d    = tout_q;
    busy      = 1'b0;
    sol_valid = 1'b0;
    solution  = '0;
    cut_size  = '0;
    unique case (state_q)
      IDLE: begin
        stab_d = '0;
        to_d   = '0;
        cut_d  = '0;
        pidx_d = '0;
        i_d    = '0;
        j_d    = IW'(1);
        tout_d = 1'b0;
        if (start) state_d = SETTLE;
      end
      SETTLE: begin
        busy = 1'b1;
        to_d = to_q + 1'b1;
        if (!same) stab_d = '0;
        else if (stab_q != STAB_MAX) stab_d = stab_q + 1'b1;
        // stability wins over a timeout landing on the same cycle
        if (same && stab_q == STAB_LAST) begin
          cap_d   = norm;
          wcap_d  = weights;
          state_d = SCORE;
        end else if (to_q == TO_LAST) begin
          cap_d   = norm;
          wcap_d  = weights;
          tout_d  = 1'b1;
          state_d = SCORE;
        end
      end
      SCORE: begin
        busy = 1'b1;
        if (pidx_q == PAIR_END) begin
          state_d = DONE;
        end else begin
          if (wcap_q[{pidx_q, 1'b0} +: 2] == 2'b00 &&
              cap_q[i_q] != cap_q[j_q])
            cut_d = cut_q + 1'b1;
          pidx_d = pidx_q + 1'b1;
          if (j_q == N_LAST) begin
            i_d = i_q + 1'b1;
            j_d = i_q + IW'(2);
          end else begin
            j_d = j_q + 1'b1;
          end
        end
      end
      DONE: begin
        sol_valid = 1'b1;
        solution  = cap_q;
        cut_size  = cut_q;
        if (sol_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign timed_out = tout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ps1_q   <= '0;
      ps2_q   <= '0;
      psp_q   <= '0;
      stab_q  <= '0;
      to_q    <= '0;
      cut_q   <= '0;
      pidx_q  <= '0;
      i_q     <= '0;
      j_q     <= '0;
      cap_q   <= '0;
      wcap_q  <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ps1_q   <= phase;
      ps2_q   <= ps1_q;
      psp_q   <= ps2_q;
      stab_q  <= stab_d;
      to_q    <= to_d;
      cut_q   <= cut_d;
      pidx_q  <= pidx_d;
      i_q     <= i_d;
      j_q     <= j_d;
      cap_q   <= cap_d;
      wcap_q  <= wcap_d;
      tout_q  <= tout_d;
    end
  end

endmodule
